// File: rtl/led_pkg.sv
// ==================================================================
// led_pkg : shared phase and mode encodings for the LED breather
// Rev 1.0
// ==================================================================
`default_nettype none

package led_pkg;

  typedef enum logic [1:0] {
    HOLD_LO = 2'd0,
    UP      = 2'd1,
    HOLD_HI = 2'd2,
    DOWN    = 2'd3
  } phase_t;

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_SOLID   = 2'b01;
  localparam logic [1:0] MODE_BLINK   = 2'b10;
  localparam logic [1:0] MODE_BREATHE = 2'b11;

endpackage

`default_nettype wire

// File: rtl/led_breather_pwm_tick_gen.sv
// ==================================================================
// pwm_tick_gen : free-running PWM period counter and brightness step tick
// Rev 1.0
// ==================================================================
`default_nettype none

module pwm_tick_gen #(
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 64
) (
  input  logic                clk_in,
  input  logic                resetn,
  input  logic                clr,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                period_end,
  output logic                step_tick
);

  localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);

  logic [STEP_W-1:0] step_cnt;

  assign period_end = (pwm_cnt == {PWM_BITS{1'b1}});
  assign step_tick  = period_end && (step_cnt == STEP_LAST);

  always_ff @(posedge clk_in or negedge resetn) begin
    if (!resetn) begin
      pwm_cnt  <= '0;
      step_cnt <= '0;
    end else if (clr) begin
      pwm_cnt  <= '0;
      step_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (period_end)
        step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_breather.sv
// ==================================================================
// led_breather : PWM LED driver with off / solid / blink / breathe modes
// Rev 1.0
// ==================================================================
`default_nettype none

module led_breather #(
  parameter int PWM_BITS   = 8,
  parameter int STEP_DIV   = 64,
  parameter int HOLD_STEPS = 32
) (
  input  logic                clk_in,
  input  logic                resetn,
  input  logic                en,
  input  logic [1:0]          mode,
  output logic                led,
  output logic [PWM_BITS-1:0] level,
  output logic [1:0]          phase
);

  import led_pkg::*;

  localparam int HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);
  localparam logic [PWM_BITS-1:0] LVL_MAX   = {PWM_BITS{1'b1}};

  logic [1:0]          mode_q;
  logic                mode_chg;
  logic                tick_clr;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                period_end;
  logic                step_tick;
  logic                hold_done;
  logic [HOLD_W-1:0]   hold_cnt;
  phase_t              state;

  assign mode_chg  = (mode != mode_q);
  assign tick_clr  = !en || mode_chg;
  assign hold_done = (hold_cnt == HOLD_LAST);
  assign phase     = state;

  pwm_tick_gen #(
    .PWM_BITS (PWM_BITS),
    .STEP_DIV (STEP_DIV)
  ) u_tick (
    .clk_in     (clk_in),
    .resetn     (resetn),
    .clr        (tick_clr),
    .pwm_cnt    (pwm_cnt),
    .period_end (period_end),
    .step_tick  (step_tick)
  );

  always_ff @(posedge clk_in or negedge resetn) begin
    if (!resetn) begin
      mode_q   <= MODE_OFF;
      led      <= 1'b0;
      level    <= '0;
      hold_cnt <= '0;
      state    <= HOLD_LO;
    end else if (!en) begin
      mode_q   <= MODE_OFF;
      led      <= 1'b0;
      level    <= '0;
      hold_cnt <= '0;
      state    <= HOLD_LO;
    end else begin
      mode_q <= mode;
      led    <= (mode == MODE_SOLID) || (mode[1] && (level > pwm_cnt));
      if (mode_chg || mode == MODE_OFF || mode == MODE_SOLID) begin
        level    <= '0;
        hold_cnt <= '0;
        state    <= HOLD_LO;
      end else if (period_end && step_tick) begin
        // Level only moves on a PWM period boundary so each period sees one duty value
        case (state)
          HOLD_LO: begin
            if (hold_done) begin
              hold_cnt <= '0;
              if (mode == MODE_BLINK) begin
                level <= LVL_MAX;
                state <= HOLD_HI;
              end else begin
                state <= UP;
              end
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          UP: begin
            hold_cnt <= '0;
            if (level != LVL_MAX) level <= level + 1'b1;
            if (level >= LVL_MAX - 1'b1) state <= HOLD_HI;
          end
          HOLD_HI: begin
            if (hold_done) begin
              hold_cnt <= '0;
              if (mode == MODE_BLINK) begin
                level <= '0;
                state <= HOLD_LO;
              end else begin
                state <= DOWN;
              end
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          DOWN: begin
            hold_cnt <= '0;
            if (level != '0) level <= level - 1'b1;
            if (level <= 1) state <= HOLD_LO;
          end
          default: state <= HOLD_LO;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_led_breather.sv
// ==================================================================
// tb_led_breather : scoreboard bench for led_breather (MAX=7, 16-cycle steps)
// Rev 1.0
// ==================================================================
`default_nettype none

module tb_led_breather;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       led;
  logic [2:0] level;
  logic [1:0] phase;

  int edges  = 0;
  int checks = 0;
  int errors = 0;
  event chk_ev;

  typedef struct {
    int         edge_no;
    string      name;
    bit         chk_led;
    bit         chk_lvl;
    bit         chk_ph;
    logic       led;
    logic [2:0] level;
    logic [1:0] phase;
  } exp_t;

  exp_t sb[$];

  led_breather #(
    .PWM_BITS   (3),
    .STEP_DIV   (2),
    .HOLD_STEPS (2)
  ) dut (
    .clk_in (clk),
    .resetn (resetn),
    .en     (en),
    .mode   (mode),
    .led    (led),
    .level  (level),
    .phase  (phase)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  function automatic void push(int e, string nm, bit cl, bit cv, bit cp,
                               logic l, logic [2:0] lv, logic [1:0] ph);
    exp_t x;
    x.edge_no = e; x.name = nm;
    x.chk_led = cl; x.chk_lvl = cv; x.chk_ph = cp;
    x.led = l; x.level = lv; x.phase = ph;
    sb.push_back(x);
  endfunction

  function automatic void exp_all(int e, string nm, logic l, logic [2:0] lv, logic [1:0] ph);
    push(e, nm, 1'b1, 1'b1, 1'b1, l, lv, ph);
  endfunction

  function automatic void exp_lp(int e, string nm, logic [2:0] lv, logic [1:0] ph);
    push(e, nm, 1'b0, 1'b1, 1'b1, 1'b0, lv, ph);
  endfunction

  function automatic void exp_led(int e, string nm, logic l);
    push(e, nm, 1'b1, 1'b0, 1'b0, l, 3'd0, 2'd0);
  endfunction

  // Monitor: pops every expectation whose edge has been reached
  initial begin
    exp_t x;
    bit   ok;
    forever begin
      @(negedge clk or chk_ev);
      while (sb.size() > 0 && sb[0].edge_no <= edges) begin
        x = sb.pop_front();
        checks++;
        ok = 1'b1;
        if (x.chk_led && led !== x.led)     ok = 1'b0;
        if (x.chk_lvl && level !== x.level) ok = 1'b0;
        if (x.chk_ph && phase !== x.phase)  ok = 1'b0;
        if (!ok) begin
          errors++;
          $display("FAIL %s @edge %0d: got led=%0b level=%0d phase=%0d, want led=%0b level=%0d phase=%0d",
                   x.name, x.edge_no, led, level, phase, x.led, x.level, x.phase);
        end
      end
    end
  end

  initial begin
    #60000;
    $display("FAIL watchdog: run did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  task automatic run_to(input int e);
    while (edges < e) @(negedge clk);
  endtask

  task automatic start_seg(input logic [1:0] m, output int b);
    @(negedge clk);
    resetn = 1'b0; en = 1'b0; mode = 2'b00;
    @(negedge clk);
    resetn = 1'b1; en = 1'b1; mode = m;
    b = edges;
  endtask

  initial begin
    int b, b2;

    // Breathe: full 288-cycle loop, duty at level 3 and level 7
    start_seg(2'b11, b);
    exp_all(b + 1, "br_start", 1'b0, 3'd0, 2'd0);
    for (int n = 2; n <= 9; n++) exp_led(b + n, "br_dark", 1'b0);
    exp_lp(b + 32,  "br_hold_lo_end", 3'd0, 2'd0);
    exp_lp(b + 33,  "br_up_entry",    3'd0, 2'd1);
    exp_lp(b + 49,  "br_up_l1",       3'd1, 2'd1);
    exp_lp(b + 81,  "br_up_l3",       3'd3, 2'd1);
    for (int n = 82; n <= 97; n++) exp_led(b + n, "duty_l3", ((n - 2) % 8) < 3);
    exp_lp(b + 97,  "br_up_l4",       3'd4, 2'd1);
    exp_lp(b + 145, "br_hold_hi",     3'd7, 2'd2);
    for (int n = 146; n <= 153; n++) exp_led(b + n, "duty_max", ((n - 2) % 8) < 7);
    exp_lp(b + 176, "br_hold_hi_end", 3'd7, 2'd2);
    exp_lp(b + 177, "br_down_entry",  3'd7, 2'd3);
    exp_lp(b + 193, "br_down_l6",     3'd6, 2'd3);
    exp_lp(b + 289, "br_back_lo",     3'd0, 2'd0);
    exp_lp(b + 320, "br_lo_again",    3'd0, 2'd0);
    exp_lp(b + 321, "br_up_again",    3'd0, 2'd1);
    run_to(b + 322);

    // Async reset mid-UP at level 4
    start_seg(2'b11, b);
    exp_lp(b + 100, "pre_reset_l4", 3'd4, 2'd1);
    run_to(b + 100);
    checks++;
    if (level !== 3'd4 || phase !== 2'd1) begin
      errors++;
      $display("FAIL direct_pre_reset: level=%0d phase=%0d", level, phase);
    end
    #2 resetn = 1'b0;
    #1 exp_all(edges, "async_reset", 1'b0, 3'd0, 2'd0);
    checks++;
    if (led !== 1'b0 || level !== 3'd0 || phase !== 2'd0) begin
      errors++;
      $display("FAIL direct_async_reset: led=%0b level=%0d phase=%0d", led, level, phase);
    end
    -> chk_ev;
    exp_all(edges + 1, "reset_held", 1'b0, 3'd0, 2'd0);
    @(negedge clk);
    resetn = 1'b1;
    b = edges;
    exp_lp(b + 1,  "post_rst_lo", 3'd0, 2'd0);
    exp_lp(b + 16, "post_rst_lo", 3'd0, 2'd0);
    exp_lp(b + 32, "post_rst_lo", 3'd0, 2'd0);
    exp_lp(b + 33, "post_rst_up", 3'd0, 2'd1);
    run_to(b + 34);

    // Solid
    start_seg(2'b01, b);
    for (int n = 2; n <= 20; n++) exp_all(b + n, "solid", 1'b1, 3'd0, 2'd0);
    run_to(b + 21);
    checks++;
    if (led !== 1'b1 || level !== 3'd0) begin
      errors++;
      $display("FAIL direct_solid: led=%0b level=%0d", led, level);
    end

    // Blink
    start_seg(2'b10, b);
    exp_lp(b + 32,  "blink_lo",  3'd0, 2'd0);
    exp_lp(b + 33,  "blink_hi",  3'd7, 2'd2);
    exp_lp(b + 64,  "blink_hi",  3'd7, 2'd2);
    exp_lp(b + 65,  "blink_lo",  3'd0, 2'd0);
    exp_lp(b + 97,  "blink_hi",  3'd7, 2'd2);
    exp_lp(b + 129, "blink_lo",  3'd0, 2'd0);
    run_to(b + 130);

    // en dropped at level 5, then resumed
    start_seg(2'b11, b);
    exp_lp(b + 113, "pre_en_l5", 3'd5, 2'd1);
    run_to(b + 115);
    en = 1'b0;
    exp_all(b + 116, "en_low_clear", 1'b0, 3'd0, 2'd0);
    exp_all(b + 119, "en_low_hold",  1'b0, 3'd0, 2'd0);
    run_to(b + 120);
    checks++;
    if (led !== 1'b0 || level !== 3'd0 || phase !== 2'd0) begin
      errors++;
      $display("FAIL direct_en_low: led=%0b level=%0d phase=%0d", led, level, phase);
    end
    en = 1'b1;
    b2 = edges;
    exp_lp(b2 + 32, "en_resume_lo", 3'd0, 2'd0);
    exp_lp(b2 + 33, "en_resume_up", 3'd0, 2'd1);
    exp_lp(b2 + 49, "en_resume_l1", 3'd1, 2'd1);
    run_to(b2 + 50);
    checks++;
    if (level !== 3'd1 || phase !== 2'd1) begin
      errors++;
      $display("FAIL direct_en_resume: level=%0d phase=%0d", level, phase);
    end

    // Mode 11 -> 10 mid-ramp
    start_seg(2'b11, b);
    exp_lp(b + 70, "pre_switch_l2", 3'd2, 2'd1);
    run_to(b + 70);
    mode = 2'b10;
    b2 = edges;
    exp_lp(b2 + 1,  "switch_restart", 3'd0, 2'd0);
    exp_lp(b2 + 32, "switch_lo",      3'd0, 2'd0);
    exp_lp(b2 + 33, "switch_blink_hi", 3'd7, 2'd2);
    exp_lp(b2 + 65, "switch_blink_lo", 3'd0, 2'd0);
    run_to(b2 + 66);

    repeat (3) @(negedge clk);
    while (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s @edge %0d: never sampled, now at edge %0d", x.name, x.edge_no, edges);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
